// File: rtl/traffic_light_sequencer_pkg.sv
// Shared definitions for the two-way traffic controller and its lamp sequencer:
// phase encoding, lamp bit positions and default phase timings.
package traffic_pkg;

    localparam logic [2:0] ST_NS_GREEN  = 3'd0;
    localparam logic [2:0] ST_NS_YELLOW = 3'd1;
    localparam logic [2:0] ST_RED_TO_EW = 3'd2;
    localparam logic [2:0] ST_EW_GREEN  = 3'd3;
    localparam logic [2:0] ST_EW_YELLOW = 3'd4;
    localparam logic [2:0] ST_RED_TO_NS = 3'd5;

    typedef enum logic [2:0] {
        NS_GREEN  = ST_NS_GREEN,
        NS_YELLOW = ST_NS_YELLOW,
        RED_TO_EW = ST_RED_TO_EW,
        EW_GREEN  = ST_EW_GREEN,
        EW_YELLOW = ST_EW_YELLOW,
        RED_TO_NS = ST_RED_TO_NS
    } state_t;

    // Bit positions inside a per-approach lamp vector
    localparam int RED    = 0;
    localparam int YELLOW = 1;
    localparam int GREEN  = 2;

    typedef logic [2:0] lamp_t;

    localparam int DEF_MIN_GREEN    = 4;
    localparam int DEF_YELLOW_TIME  = 2;
    localparam int DEF_ALL_RED_TIME = 1;
    localparam int DEF_CNT_W        = 8;

    function automatic logic is_transition(input state_t s);
        return (s == NS_YELLOW) || (s == RED_TO_EW) ||
               (s == EW_YELLOW) || (s == RED_TO_NS);
    endfunction

endpackage

// File: rtl/traffic_light_sequencer_if.sv
// Request/lamp bundle between the traffic controller (master) and the
// lamp sequencer (slave); names are from the sequencer's point of view.
interface traffic_light_sequencer_if;

    logic i_Ewgreen;
    logic i_Nsgreen;
    logic o_Ewred;
    logic o_Ewyellow;
    logic o_Ewgreen;
    logic o_Nsred;
    logic o_Nsyellow;
    logic o_Nsgreen;
    logic o_busy;

    modport master (
        output i_Ewgreen, i_Nsgreen,
        input  o_Ewred, o_Ewyellow, o_Ewgreen,
        input  o_Nsred, o_Nsyellow, o_Nsgreen, o_busy
    );

    modport slave (
        input  i_Ewgreen, i_Nsgreen,
        output o_Ewred, o_Ewyellow, o_Ewgreen,
        output o_Nsred, o_Nsyellow, o_Nsgreen, o_busy
    );

endinterface

// File: rtl/traffic_light_sequencer_phase_timer.sv
// Saturating phase timer: counts cycles spent in the current phase, clears
// synchronously on reset or on a phase change and sticks at all-ones.
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_clear,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear) begin
            r_count <= '0;
        end else if (r_count != {CNT_W{1'b1}}) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/traffic_light_sequencer.sv
// Turns the controller's raw green-direction request into a timed, safe
// six-phase lamp sequence with minimum green, yellow and all-red clearance.
module traffic_light_sequencer
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN    = DEF_MIN_GREEN,
    parameter int YELLOW_TIME  = DEF_YELLOW_TIME,
    parameter int ALL_RED_TIME = DEF_ALL_RED_TIME,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    traffic_light_sequencer_if.slave  bus
);

    localparam logic [CNT_W-1:0] C_GREEN_LAST  = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] C_YELLOW_LAST = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] C_RED_LAST    = CNT_W'(ALL_RED_TIME - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] w_timer;
    logic             w_clear;
    logic             w_want_ew;
    logic             w_want_ns;
    lamp_t            w_ew_lamp;
    lamp_t            w_ns_lamp;
    logic             w_conflict;

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_clear (w_clear),
        .o_count (w_timer)
    );

    // Contradictory or empty requests decode to neither, i.e. hold the current green
    assign w_want_ew = bus.i_Ewgreen & ~bus.i_Nsgreen;
    assign w_want_ns = bus.i_Nsgreen & ~bus.i_Ewgreen;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= NS_GREEN;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_ew_lamp = '0;
        w_ns_lamp = '0;
        case (r_state)
            NS_GREEN: begin
                w_ns_lamp[GREEN] = 1'b1;
                w_ew_lamp[RED]   = 1'b1;
                if ((w_timer >= C_GREEN_LAST) && w_want_ew) begin
                    w_next = NS_YELLOW;
                end
            end
            NS_YELLOW: begin
                w_ns_lamp[YELLOW] = 1'b1;
                w_ew_lamp[RED]    = 1'b1;
                if (w_timer == C_YELLOW_LAST) begin
                    w_next = RED_TO_EW;
                end
            end
            RED_TO_EW: begin
                w_ns_lamp[RED] = 1'b1;
                w_ew_lamp[RED] = 1'b1;
                if (w_timer == C_RED_LAST) begin
                    w_next = EW_GREEN;
                end
            end
            EW_GREEN: begin
                w_ew_lamp[GREEN] = 1'b1;
                w_ns_lamp[RED]   = 1'b1;
                if ((w_timer >= C_GREEN_LAST) && w_want_ns) begin
                    w_next = EW_YELLOW;
                end
            end
            EW_YELLOW: begin
                w_ew_lamp[YELLOW] = 1'b1;
                w_ns_lamp[RED]    = 1'b1;
                if (w_timer == C_YELLOW_LAST) begin
                    w_next = RED_TO_NS;
                end
            end
            RED_TO_NS: begin
                w_ns_lamp[RED] = 1'b1;
                w_ew_lamp[RED] = 1'b1;
                if (w_timer == C_RED_LAST) begin
                    w_next = NS_GREEN;
                end
            end
            default: begin
                w_ns_lamp[RED] = 1'b1;
                w_ew_lamp[RED] = 1'b1;
                w_next         = NS_GREEN;
            end
        endcase
    end

    assign w_clear = (w_next != r_state);

    // Last-line guard: if both approaches ever decode non-red, show all red
    assign w_conflict = ~w_ew_lamp[RED] & ~w_ns_lamp[RED];

    assign bus.o_Ewred    = w_conflict | w_ew_lamp[RED];
    assign bus.o_Ewyellow = ~w_conflict & w_ew_lamp[YELLOW];
    assign bus.o_Ewgreen  = ~w_conflict & w_ew_lamp[GREEN];
    assign bus.o_Nsred    = w_conflict | w_ns_lamp[RED];
    assign bus.o_Nsyellow = ~w_conflict & w_ns_lamp[YELLOW];
    assign bus.o_Nsgreen  = ~w_conflict & w_ns_lamp[GREEN];
    assign bus.o_busy     = is_transition(r_state);

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Scoreboard bench: the driver runs a phase/dwell reference model and queues
// the expected lamps; a monitor pops and compares one entry per clock.
module tb_traffic_light_sequencer;

    localparam int MIN_GREEN    = 4;
    localparam int YELLOW_TIME  = 2;
    localparam int ALL_RED_TIME = 1;

    logic clk = 1'b0;
    logic i_reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    logic [6:0] sb_q[$];

    // Reference model: phase 0..5 in order NSg, NSy, red, EWg, EWy, red
    int m_phase = 0;
    int m_dwell = 0;

    traffic_light_sequencer_if io ();

    traffic_light_sequencer #(
        .MIN_GREEN    (MIN_GREEN),
        .YELLOW_TIME  (YELLOW_TIME),
        .ALL_RED_TIME (ALL_RED_TIME),
        .CNT_W        (8)
    ) dut (
        .i_clock (clk),
        .i_reset (i_reset),
        .bus     (io)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] expect_vec(input int p);
        logic ewr, ewy, ewg, nsr, nsy, nsg;
        nsg = (p == 0);
        nsy = (p == 1);
        nsr = !(nsg || nsy);
        ewg = (p == 3);
        ewy = (p == 4);
        ewr = !(ewg || ewy);
        return {ewr, ewy, ewg, nsr, nsy, nsg, logic'((p % 3) != 0)};
    endfunction

    task automatic model_edge(input logic rst, input logic ew, input logic ns);
        bit leave;
        leave = 1'b0;
        if (rst) begin
            m_phase = 0;
            m_dwell = 0;
        end else begin
            case (m_phase % 3)
                0: leave = (m_dwell + 1 >= MIN_GREEN) &&
                           ((m_phase == 0) ? (ew && !ns) : (ns && !ew));
                1: leave = (m_dwell + 1 == YELLOW_TIME);
                default: leave = (m_dwell + 1 == ALL_RED_TIME);
            endcase
            if (leave) begin
                m_phase = (m_phase + 1) % 6;
                m_dwell = 0;
            end else begin
                m_dwell = m_dwell + 1;
            end
        end
    endtask

    task automatic step(input logic rst, input logic ew, input logic ns);
        @(negedge clk);
        i_reset      = rst;
        io.i_Ewgreen = ew;
        io.i_Nsgreen = ns;
        model_edge(rst, ew, ns);
        sb_q.push_back(expect_vec(m_phase));
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    // Monitor: one expected entry per clock once the driver has started
    always @(posedge clk) begin
        logic [6:0] act;
        logic [6:0] exp_v;
        cyc++;
        #1;
        act = {io.o_Ewred, io.o_Ewyellow, io.o_Ewgreen,
               io.o_Nsred, io.o_Nsyellow, io.o_Nsgreen, io.o_busy};
        if (sb_q.size() > 0) begin
            exp_v = sb_q.pop_front();
            n_cmp++;
            if (act !== exp_v) begin
                n_bad++;
                $display("FAIL lamps cyc=%0d actual=%b required=%b", cyc, act, exp_v);
            end
            n_cmp++;
            if (!($countones(act[6:4]) == 1 && $countones(act[3:1]) == 1 &&
                  (act[6] || act[3]))) begin
                n_bad++;
                $display("FAIL safety cyc=%0d actual=%b required=one-hot-per-approach,one-red", cyc, act);
            end
        end
    end

    initial begin
        int cnt;
        int cur_dir;
        int r;
        i_reset      = 1'b1;
        io.i_Ewgreen = 1'b0;
        io.i_Nsgreen = 1'b0;

        // NS request held: NS green throughout
        step(1, 0, 1);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            step(0, 0, 1);
            settle();
            if (io.o_Nsgreen && io.o_Ewred && !io.o_busy) cnt++;
        end
        chk("ns_hold_green", cnt, 20);

        // EW request from reset: yellow cycles 4-5, all red 6, EW green 7
        step(1, 1, 0);
        for (int k = 0; k < 6; k++) step(0, 1, 0);
        settle();
        chk("all_red_cycle6", int'(io.o_Ewred && io.o_Nsred && io.o_busy), 1);
        step(0, 1, 0);
        settle();
        chk("ew_green_cycle7", int'(io.o_Ewgreen && !io.o_busy), 1);

        // Late request after long NS green
        step(1, 0, 1);
        for (int k = 0; k < 10; k++) step(0, 0, 1);
        step(0, 1, 0);
        settle();
        chk("late_req_yellow", int'(io.o_Nsyellow), 1);
        for (int k = 0; k < 3; k++) step(0, 1, 0);
        settle();
        chk("late_req_ew_green", int'(io.o_Ewgreen), 1);

        // Invalid requests hold EW green
        for (int k = 0; k < 15; k++) step(0, 1, 1);
        for (int k = 0; k < 15; k++) step(0, 0, 0);
        settle();
        chk("invalid_hold_ew", int'(io.o_Ewgreen), 1);

        // Revert to NS during NS yellow: commit to EW, hold 4, return to NS
        step(1, 1, 0);
        for (int k = 0; k < 20 && m_phase != 1; k++) step(0, 1, 0);
        cnt = 0;
        for (int k = 0; k < 14; k++) begin
            step(0, 0, 1);
            settle();
            if (io.o_Ewgreen) cnt++;
        end
        chk("revert_ew_hold", cnt, 4);
        chk("revert_back_ns", int'(io.o_Nsgreen), 1);

        // Reset during RED_TO_EW restarts NS minimum green
        step(1, 1, 0);
        for (int k = 0; k < 20 && m_phase != 2; k++) step(0, 1, 0);
        step(1, 1, 0);
        settle();
        chk("midseq_reset_ns", int'(io.o_Nsgreen && io.o_Ewred && !io.o_busy), 1);
        cnt = 1;
        for (int k = 0; k < 6; k++) begin
            step(0, 1, 0);
            settle();
            if (io.o_Nsgreen) cnt++;
        end
        chk("midseq_reset_min_green", cnt, 4);

        // Timer must saturate: request exactly where a wrapped timer reads 0
        step(1, 0, 1);
        for (int k = 0; k < 256; k++) step(0, 0, 1);
        step(0, 1, 0);
        settle();
        chk("saturate_exit", int'(io.o_Nsyellow), 1);

        // Randomized traffic with occasional resets and invalid requests
        cur_dir = 0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 7) == 0) cur_dir = 1 - cur_dir;
            r = $urandom_range(0, 9);
            if (r == 0)      step($urandom_range(0, 199) == 0, 1, 1);
            else if (r == 1) step($urandom_range(0, 199) == 0, 0, 0);
            else             step($urandom_range(0, 199) == 0,
                                  logic'(cur_dir == 1), logic'(cur_dir == 0));
        end

        @(posedge clk);
        #3;
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
